// File: rtl/alu_pkg.sv
// Shared opcode, flag and limit definitions for the pipelined ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_NAND = 4'd4,
        OP_AND  = 4'd5,
        OP_XNOR = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int ALU_OP_LAST = 12;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> (x, NZCV flags, illegal-op error).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] x,
    output alu_flags_t       flags,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH:0]          sum_w;
    logic [WIDTH:0]          dif_w;
    logic [SHW-1:0]          shamt;
    logic                    c_f;
    logic                    v_f;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SHW-1:0];
    assign sum_w = {1'b0, a} + {1'b0, b};
    // Subtraction as A + ~B + 1 so carry-out means "no borrow".
    assign dif_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        x   = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADD: begin
                x   = sum_w[WIDTH-1:0];
                c_f = sum_w[WIDTH];
                v_f = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                x   = dif_w[WIDTH-1:0];
                c_f = dif_w[WIDTH];
                v_f = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR:  x = ~(a | b);
            OP_OR:   x = a | b;
            OP_NAND: x = ~(a & b);
            OP_AND:  x = a & b;
            OP_XNOR: x = ~(a ^ b);
            OP_XOR:  x = a ^ b;
            OP_SLL:  x = a << shamt;
            OP_SRL:  x = a >> shamt;
            OP_SRA:  x = a_s >>> shamt;
            OP_SLT:  x = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: x = {{(WIDTH-1){1'b0}}, (a < b)};
            default: err = 1'b1;
        endcase
    end

    // Illegal opcodes report all-zero flags, including Z.
    always_comb begin
        flags.n = x[WIDTH-1] & ~err;
        flags.z = (x == '0) & ~err;
        flags.c = c_f;
        flags.v = v_f;
    end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ALU pipeline with valid/ready handshakes; absorbs downstream stalls
// with at most two operations in flight.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [3:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] x_p2;
    alu_flags_t       flags_p2;
    logic             err_p2;
    logic [TAG_W-1:0] tag_p2;

    logic [WIDTH-1:0] core_x;
    alu_flags_t       core_flags;
    logic             core_err;

    logic             s2_load;
    logic             accept;

    assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s2_load;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (s2_load)
                vld_p1 <= 1'b0;

            if (s2_load)
                vld_p2 <= 1'b1;
            else if (out_ready)
                vld_p2 <= 1'b0;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= in_a;
            b_p1   <= in_b;
            op_p1  <= in_op;
            tag_p1 <= in_tag;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_p1),
        .b     (b_p1),
        .op    (op_p1),
        .x     (core_x),
        .flags (core_flags),
        .err   (core_err)
    );

    // Stage 2: result capture
    always_ff @(posedge clk) begin
        if (s2_load) begin
            x_p2     <= core_x;
            flags_p2 <= core_flags;
            err_p2   <= core_err;
            tag_p2   <= tag_p1;
        end
    end

    // Data registers are not reset, so outputs are masked by the valid bit.
    assign out_valid = vld_p2;
    assign out_x     = vld_p2 ? x_p2     : '0;
    assign out_flags = vld_p2 ? flags_p2 : '0;
    assign out_err   = vld_p2 ? err_p2   : 1'b0;
    assign out_tag   = vld_p2 ? tag_p2   : '0;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed vector table, streaming
// scoreboard with random back-pressure, stall/fill and asynchronous reset.
module tb_pipelined_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int NV    = 22;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [3:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_x;
    logic [3:0]       out_flags;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_flags (out_flags),
        .out_err   (out_err),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] x;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    vec_t vecs [NV];
    vec_t exp_q [$];
    vec_t cur;

    int   checks = 0;
    int   errors = 0;
    int   occ = 0;
    int   n_acc = 0;
    int   n_cons = 0;
    logic last_acc = 1'b0;
    logic last_cons = 1'b0;
    logic stalled = 1'b0;
    logic [41:0] saved_out = '0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic [31:0] x,
                                input logic [3:0] flags, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.x = x; v.flags = flags; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [3:0] tag);
        in_a   = v.a;
        in_b   = v.b;
        in_op  = v.op;
        in_tag = tag;
        cur    = v;
        cur.tag = tag;
    endtask

    // One clock of the scoreboarded flow. Called at a negedge with inputs set.
    task automatic tick();
        #1;
        chk("in_ready_rule", in_ready, !(occ == 2 && !out_ready));
        if (stalled)
            chk("stall_hold", {out_valid, out_x, out_flags, out_err, out_tag}, saved_out);
        last_acc  = in_valid && in_ready;
        last_cons = out_valid && out_ready;
        if (last_cons) begin
            if (exp_q.size() == 0)
                chk("spurious_result", 1, 0);
            else
                chk("stream_result", {out_x, out_flags, out_err, out_tag},
                    {exp_q[0].x, exp_q[0].flags, exp_q[0].err, exp_q[0].tag});
        end
        stalled   = out_valid && !out_ready;
        saved_out = {out_valid, out_x, out_flags, out_err, out_tag};
        @(posedge clk);
        if (last_cons) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            occ--;
            n_cons++;
        end
        if (last_acc) begin
            exp_q.push_back(cur);
            occ++;
            n_acc++;
        end
        @(negedge clk);
    endtask

    // Single op into an empty pipeline with out_ready=1; checks the two-edge latency.
    task automatic send_check(input vec_t v, input string name);
        drive(v, v.tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({name, "_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({name, "_early"}, out_valid, 0);
        @(posedge clk);
        #1 chk({name, "_valid"}, out_valid, 1);
        chk(name, {out_x, out_flags, out_err, out_tag}, {v.x, v.flags, v.err, v.tag});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        int a0;

        //             op     a             b             tag    x             NZCV     err
        vecs[0]  = mk(4'd0,  32'hFFFFFFFF, 32'h00000001, 4'h1, 32'h00000000, 4'b0110, 1'b0);
        vecs[1]  = mk(4'd0,  32'h7FFFFFFF, 32'h00000001, 4'h2, 32'h80000000, 4'b1001, 1'b0);
        vecs[2]  = mk(4'd1,  32'h00000005, 32'h00000007, 4'h3, 32'hFFFFFFFE, 4'b1000, 1'b0);
        vecs[3]  = mk(4'd1,  32'h00000007, 32'h00000005, 4'h4, 32'h00000002, 4'b0010, 1'b0);
        vecs[4]  = mk(4'd11, 32'hFFFFFFFF, 32'h00000001, 4'h5, 32'h00000001, 4'b0000, 1'b0);
        vecs[5]  = mk(4'd12, 32'hFFFFFFFF, 32'h00000001, 4'h6, 32'h00000000, 4'b0100, 1'b0);
        vecs[6]  = mk(4'd10, 32'h80000000, 32'h00000021, 4'h7, 32'hC0000000, 4'b1000, 1'b0);
        vecs[7]  = mk(4'd14, 32'h00001234, 32'h00005678, 4'hA, 32'h00000000, 4'b0000, 1'b1);
        vecs[8]  = mk(4'd2,  32'hF0F0F0F0, 32'h0F0F0F00, 4'h8, 32'h0000000F, 4'b0000, 1'b0);
        vecs[9]  = mk(4'd3,  32'h00000000, 32'h00000000, 4'h9, 32'h00000000, 4'b0100, 1'b0);
        vecs[10] = mk(4'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'hB, 32'h00000000, 4'b0100, 1'b0);
        vecs[11] = mk(4'd5,  32'h12345678, 32'hFF00FF00, 4'hC, 32'h12005600, 4'b0000, 1'b0);
        vecs[12] = mk(4'd6,  32'hAAAAAAAA, 32'h55555555, 4'hD, 32'h00000000, 4'b0100, 1'b0);
        vecs[13] = mk(4'd7,  32'h80000000, 32'h00000001, 4'hE, 32'h80000001, 4'b1000, 1'b0);
        vecs[14] = mk(4'd8,  32'h00000001, 32'h0000001F, 4'hF, 32'h80000000, 4'b1000, 1'b0);
        vecs[15] = mk(4'd9,  32'h80000000, 32'h00000024, 4'h0, 32'h08000000, 4'b0000, 1'b0);
        vecs[16] = mk(4'd1,  32'h80000000, 32'h00000001, 4'h1, 32'h7FFFFFFF, 4'b0011, 1'b0);
        vecs[17] = mk(4'd1,  32'h00000005, 32'h00000005, 4'h2, 32'h00000000, 4'b0110, 1'b0);
        vecs[18] = mk(4'd11, 32'h00000001, 32'hFFFFFFFF, 4'h3, 32'h00000000, 4'b0100, 1'b0);
        vecs[19] = mk(4'd12, 32'h00000001, 32'hFFFFFFFF, 4'h4, 32'h00000001, 4'b0000, 1'b0);
        vecs[20] = mk(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h5, 32'h00000000, 4'b0000, 1'b1);
        vecs[21] = mk(4'd15, 32'h7FFFFFFF, 32'h00000001, 4'h6, 32'h00000000, 4'b0000, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {out_valid, out_x, out_flags, out_err, out_tag}, 0);
        resetn = 1'b1;
        #1 chk("ready_after_init", in_ready, 1);
        @(negedge clk);

        // Directed vectors, one at a time
        for (int i = 0; i < NV; i++)
            send_check(vecs[i], $sformatf("vec%0d", i));
        @(posedge clk);
        @(negedge clk);
        chk("idle_empty", out_valid, 0);

        // Back-to-back stream with random back-pressure
        idx = 0;
        cyc = 0;
        n_cons = 0;
        while (n_cons < 20 && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (idx < 20) begin
                drive(vecs[idx % NV], idx[3:0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_acc) idx++;
            cyc++;
        end
        chk("stream_count", n_cons, 20);
        chk("stream_queue_empty", exp_q.size(), 0);

        // Stall with continuous offers: exactly two ops buffered
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        a0 = n_acc;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[(i + 3) % NV], 4'(i + 8));
            in_valid = 1'b1;
            tick();
        end
        chk("stall_accepts", n_acc - a0, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[(i + 10) % NV], 4'(i));
            in_valid = 1'b1;
            tick();
            chk("flow_accept", last_acc, 1);
            chk("flow_consume", last_cons, 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            tick();
        chk("drain_empty", exp_q.size(), 0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i], 4'(i + 1));
            in_valid = 1'b1;
            tick();
        end
        chk("full_before_reset", {out_valid, in_ready}, 2'b10);
        #2 resetn = 1'b0;
        #1 chk("async_reset", {out_valid, out_x, out_flags, out_err, out_tag}, 0);
        in_valid = 1'b0;
        exp_q.delete();
        occ = 0;
        stalled = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1 chk("ready_after_reset", in_ready, 1);
        chk("empty_after_reset", out_valid, 0);
        @(negedge clk);
        send_check(vecs[1], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
